// File: rtl/udt_data_tx_framer.sv
// udt_data_tx_framer: prepends the 16-byte UDT data header to socket-tagged payload packets (define UDT_TX_TSTAMP_EN for the microsecond timestamp in word2)
module udt_data_tx_framer #(
  parameter int          NUM_SOCK     = 4,
  parameter int          SOCK_W       = 2,
  parameter logic [47:0] FPGA_MAC_SRC = 48'hba0203040506,
  parameter logic [47:0] FPGA_MAC_DES = 48'hffffffffffff,
  parameter logic [31:0] FPGA_IP_SRC  = 32'hc0a8006f,
  parameter logic [15:0] PORT         = 16'd10086,
  parameter int          CLK_PER_US   = 156
) (
  input  logic              udp_clk,
  input  logic              udp_areset,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [63:0]       s_axis_tdata,
  input  logic [7:0]        s_axis_tkeep,
  input  logic              s_axis_tlast,
  input  logic [SOCK_W-1:0] s_axis_tdest,
  input  logic              cfg_we,
  input  logic [SOCK_W-1:0] cfg_sock,
  input  logic [31:0]       cfg_ip_dest,
  input  logic [15:0]       cfg_port_dest,
  input  logic [31:0]       cfg_peer_id,
  input  logic [30:0]       cfg_seq_init,
  input  logic              udp_tx_tready,
  output logic              udp_tx_tvalid,
  output logic              udp_tx_tlast,
  output logic [7:0]        udp_tx_tkeep,
  output logic [63:0]       udp_tx_tdata,
  output logic [47:0]       udp_tx_mac_src,
  output logic [47:0]       udp_tx_mac_dest,
  output logic [31:0]       udp_tx_ip_src,
  output logic [31:0]       udp_tx_ip_dest,
  output logic [15:0]       udp_tx_port_src,
  output logic [15:0]       udp_tx_port_dest,
  output logic              err_bad_sock
);
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, DROP} state_t;
  state_t      r_st;
  logic [31:0] r_ip   [NUM_SOCK];
  logic [15:0] r_port [NUM_SOCK];
  logic [31:0] r_peer [NUM_SOCK];
  logic [30:0] r_seq  [NUM_SOCK];
  logic [28:0] r_msg  [NUM_SOCK];
  logic [SOCK_W-1:0] r_sock;
  logic [31:0] r_p_ip, r_p_peer, r_p_ts;
  logic [15:0] r_p_port;
  logic [30:0] r_p_seq;
  logic [28:0] r_p_msg;
  logic        r_err;
  logic        w_ok, w_eop, w_drop_end;
  logic [31:0] w_ip, w_peer, w_ts;
  logic [15:0] w_port;
  logic [30:0] w_seq;
  logic [28:0] w_msg;
  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction
  assign w_eop      = r_st == DATA && s_axis_tvalid && udp_tx_tready && s_axis_tlast;
  assign w_drop_end = r_st == DROP && s_axis_tvalid && s_axis_tlast;
  // table lookup for the socket named on the first beat; out-of-range index leaves w_ok low
  always_comb begin
    w_ok = 1'b0;
    w_ip = '0;
    w_port = '0;
    w_peer = '0;
    w_seq = '0;
    w_msg = '0;
    for (int s = 0; s < NUM_SOCK; s++)
      if (s_axis_tdest == SOCK_W'(s)) begin
        w_ok = 1'b1;
        w_ip = r_ip[s];
        w_port = r_port[s];
        w_peer = r_peer[s];
        w_seq = r_seq[s];
        w_msg = r_msg[s];
      end
  end
  // socket table: config write takes priority over the end-of-packet increment
  always_ff @(posedge udp_clk) begin
    for (int s = 0; s < NUM_SOCK; s++)
      if (udp_areset) begin
        r_ip[s] <= '0;
        r_port[s] <= '0;
        r_peer[s] <= '0;
        r_seq[s] <= '0;
        r_msg[s] <= '0;
      end else if (cfg_we && cfg_sock == SOCK_W'(s)) begin
        r_ip[s] <= cfg_ip_dest;
        r_port[s] <= cfg_port_dest;
        r_peer[s] <= cfg_peer_id;
        r_seq[s] <= cfg_seq_init;
        r_msg[s] <= '0;
      end else if (w_eop && r_sock == SOCK_W'(s)) begin
        r_seq[s] <= r_seq[s] + 31'd1;
        r_msg[s] <= r_msg[s] + 29'd1;
      end
  end
`ifdef UDT_TX_TSTAMP_EN
  logic [31:0] r_pre, r_us;
  // microsecond timestamp: prescaler wraps every CLK_PER_US cycles
  always_ff @(posedge udp_clk) begin
    if (udp_areset) begin
      r_pre <= '0;
      r_us <= '0;
    end else begin
      r_pre <= r_pre == 32'(CLK_PER_US - 1) ? '0 : r_pre + 32'd1;
      r_us <= r_pre == 32'(CLK_PER_US - 1) ? r_us + 32'd1 : r_us;
    end
  end
  assign w_ts = r_us;
`else
  assign w_ts = '0;
`endif
  // framing FSM; packet registers snapshot the table so mid-packet config writes cannot leak in
  always_ff @(posedge udp_clk) begin
    if (udp_areset) begin
      r_st <= IDLE;
      r_err <= 1'b0;
      r_sock <= '0;
      r_p_ip <= '0;
      r_p_port <= '0;
      r_p_peer <= '0;
      r_p_seq <= '0;
      r_p_msg <= '0;
      r_p_ts <= '0;
    end else begin
      r_err <= w_drop_end;
      case (r_st)
        IDLE: if (s_axis_tvalid) begin
          r_st <= w_ok ? HDR0 : DROP;
          r_sock <= s_axis_tdest;
          r_p_ip <= w_ip;
          r_p_port <= w_port;
          r_p_peer <= w_peer;
          r_p_seq <= w_seq;
          r_p_msg <= w_msg;
          r_p_ts <= w_ts;
        end
        HDR0: r_st <= udp_tx_tready ? HDR1 : HDR0;
        HDR1: r_st <= udp_tx_tready ? DATA : HDR1;
        DATA: r_st <= w_eop ? IDLE : DATA;
        DROP: r_st <= w_drop_end ? IDLE : DROP;
        default: r_st <= IDLE;
      endcase
    end
  end
  assign s_axis_tready    = r_st == DATA ? udp_tx_tready : r_st == DROP;
  assign udp_tx_tvalid    = r_st == HDR0 || r_st == HDR1 || (r_st == DATA && s_axis_tvalid);
  assign udp_tx_tlast     = r_st == DATA && s_axis_tlast;
  assign udp_tx_tkeep     = r_st == DATA ? s_axis_tkeep : (r_st == HDR0 || r_st == HDR1) ? 8'hFF : 8'h00;
  assign udp_tx_tdata     = r_st == HDR0 ? {bswap({3'b110, r_p_msg}), bswap({1'b0, r_p_seq})} :
                            r_st == HDR1 ? {bswap(r_p_peer), bswap(r_p_ts)} :
                            r_st == DATA ? s_axis_tdata : 64'h0;
  assign udp_tx_mac_src   = FPGA_MAC_SRC;
  assign udp_tx_mac_dest  = FPGA_MAC_DES;
  assign udp_tx_ip_src    = FPGA_IP_SRC;
  assign udp_tx_port_src  = PORT;
  assign udp_tx_ip_dest   = r_p_ip;
  assign udp_tx_port_dest = r_p_port;
  assign err_bad_sock     = r_err;
endmodule

// File: tb/tb_udt_data_tx_framer.sv
// tb_udt_data_tx_framer: directed bench for the UDT data framer (NUM_SOCK=3, CLK_PER_US=4)
module tb_udt_data_tx_framer;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic s_tvalid = 0, s_tready, s_tlast = 0;
  logic [63:0] s_tdata = '0;
  logic [7:0] s_tkeep = '0;
  logic [1:0] s_tdest = '0;
  logic cfg_we = 0;
  logic [1:0] cfg_sock = '0;
  logic [31:0] cfg_ip = '0, cfg_peer = '0;
  logic [15:0] cfg_port = '0;
  logic [30:0] cfg_seq = '0;
  logic udp_tready = 1, udp_tvalid, udp_tlast, err;
  logic [7:0] udp_tkeep;
  logic [63:0] udp_tdata;
  logic [47:0] mac_src, mac_dest;
  logic [31:0] ip_src, ip_dest;
  logic [15:0] port_src, port_dest;
  int n_chk = 0, n_pass = 0, n_valid = 0, n_err = 0;
  logic rnd = 0, stall;
  logic [63:0] stall_d;
  logic [120:0] q[$];
  logic [31:0] ts;
  udt_data_tx_framer #(.NUM_SOCK(3), .SOCK_W(2), .CLK_PER_US(4)) dut (
    .udp_clk(clk), .udp_areset(rst),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast), .s_axis_tdest(s_tdest),
    .cfg_we(cfg_we), .cfg_sock(cfg_sock), .cfg_ip_dest(cfg_ip), .cfg_port_dest(cfg_port),
    .cfg_peer_id(cfg_peer), .cfg_seq_init(cfg_seq),
    .udp_tx_tready(udp_tready), .udp_tx_tvalid(udp_tvalid), .udp_tx_tlast(udp_tlast),
    .udp_tx_tkeep(udp_tkeep), .udp_tx_tdata(udp_tdata),
    .udp_tx_mac_src(mac_src), .udp_tx_mac_dest(mac_dest), .udp_tx_ip_src(ip_src),
    .udp_tx_ip_dest(ip_dest), .udp_tx_port_src(port_src), .udp_tx_port_dest(port_dest),
    .err_bad_sock(err)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [63:0] hb(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    for (int k = 0; k < 4; k++) begin
      r[8*k +: 8] = a[31-8*k -: 8];
      r[32+8*k +: 8] = b[31-8*k -: 8];
    end
    return r;
  endfunction
  initial begin
    stall = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (stall) begin
          chk("hold_valid", 64'(udp_tvalid), 64'd1);
          chk("hold_data", udp_tdata, stall_d);
        end
        if (udp_tvalid) n_valid++;
        if (err) n_err++;
        if (udp_tvalid && udp_tready) q.push_back({udp_tlast, udp_tkeep, ip_dest, port_dest, udp_tdata});
        stall = udp_tvalid && !udp_tready;
        stall_d = udp_tdata;
      end else stall = 0;
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd) udp_tready = 1'($urandom_range(0, 1));
  end
  task automatic wait_hs();
    int t = 0;
    @(negedge clk);
    while (!s_tready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!s_tready) chk("hs_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [1:0] d, input int n, input logic [7:0] lk, input logic [63:0] base, input logic col);
    for (int i = 0; i < n; i++) begin
      s_tvalid = 1;
      s_tdest = d;
      s_tdata = base + 64'(i);
      s_tkeep = i == n - 1 ? lk : 8'hFF;
      s_tlast = i == n - 1;
      if (col && i == n - 1) begin
        cfg_sock = d;
        cfg_seq = 31'd5;
        cfg_we = 1;
      end
      wait_hs();
      cfg_we = 0;
    end
    s_tvalid = 0;
    s_tlast = 0;
  endtask
  task automatic cfg(input logic [1:0] s, input logic [31:0] ip, input logic [15:0] pt, input logic [31:0] pr, input logic [30:0] sq);
    cfg_sock = s;
    cfg_ip = ip;
    cfg_port = pt;
    cfg_peer = pr;
    cfg_seq = sq;
    cfg_we = 1;
    @(posedge clk);
    #1;
    cfg_we = 0;
  endtask
  task automatic check_pkt(input string nm, input logic [30:0] seq, input logic [28:0] msg, input logic [31:0] peer,
                           input logic [31:0] ip, input logic [15:0] port, input int n, input logic [7:0] lk,
                           input logic [63:0] base, output logic [31:0] ts_o);
    logic [120:0] e;
    logic [63:0] h1;
    int t = 0;
    ts_o = '0;
    while (q.size() < n + 2 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != n + 2) begin
      chk({nm, "_beats"}, 64'(q.size()), 64'(n + 2));
      q.delete();
      return;
    end
    h1 = hb(32'd0, peer);
    for (int i = 0; i < n + 2; i++) begin
      e = q.pop_front();
      chk({nm, "_side"}, {16'd0, e[111:64]}, {16'd0, ip, port});
      chk({nm, "_last_keep"}, 64'(e[120:112]), i == n + 1 ? {55'd0, 1'b1, lk} : 64'h0FF);
      if (i == 0) chk({nm, "_hdr0"}, e[63:0], hb({1'b0, seq}, {3'b110, msg}));
      else if (i == 1) begin
        chk({nm, "_peer"}, {32'd0, e[63:32]}, {32'd0, h1[63:32]});
        ts_o = {e[7:0], e[15:8], e[23:16], e[31:24]};
      end else chk({nm, "_data"}, e[63:0], base + 64'(i - 2));
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 64'(udp_tvalid), 64'd0);
    chk("rst_sready", 64'(s_tready), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_tlast", 64'(udp_tlast), 64'd0);
    chk("rst_tdata", udp_tdata, 64'd0);
    chk("rst_tkeep", 64'(udp_tkeep), 64'd0);
    chk("rst_side", {16'd0, ip_dest, port_dest}, 64'd0);
    chk("const_side", {mac_src[15:0], ip_src, port_src}, {16'h0506, 32'hc0a8006f, 16'd10086});
    @(posedge clk);
    #1 rst = 0;
    cfg(2'd1, 32'hC0A80010, 16'd9000, 32'h55, 31'd100);
    send(2'd1, 3, 8'h0F, 64'hA000_0000_0000_0010, 0);
    if (q.size() > 0) chk("basic_beat0_bytes", q[0][63:0], 64'h000000C064000000);
    check_pkt("basic", 31'd100, 29'd0, 32'h55, 32'hC0A80010, 16'd9000, 3, 8'h0F, 64'hA000_0000_0000_0010, ts);
`ifndef UDT_TX_TSTAMP_EN
    chk("basic_ts_zero", 64'(ts), 64'd0);
`endif
    send(2'd0, 1, 8'hFF, 64'hB000_0000_0000_0020, 0);
    check_pkt("sock0", 31'd0, 29'd0, 32'd0, 32'd0, 16'd0, 1, 8'hFF, 64'hB000_0000_0000_0020, ts);
    send(2'd1, 2, 8'h01, 64'hC000_0000_0000_0030, 0);
    check_pkt("seq_adv", 31'd101, 29'd1, 32'h55, 32'hC0A80010, 16'd9000, 2, 8'h01, 64'hC000_0000_0000_0030, ts);
    rnd = 1;
    send(2'd1, 4, 8'h3F, 64'hD000_0000_0000_0040, 0);
    rnd = 0;
    @(posedge clk);
    #2 udp_tready = 1;
    check_pkt("bp", 31'd102, 29'd2, 32'h55, 32'hC0A80010, 16'd9000, 4, 8'h3F, 64'hD000_0000_0000_0040, ts);
    @(posedge clk);
    #1;
    n_valid = 0;
    n_err = 0;
    send(2'd3, 2, 8'hFF, 64'hE000_0000_0000_0050, 0);
    repeat (3) @(negedge clk);
    chk("bad_no_valid", 64'(n_valid), 64'd0);
    chk("bad_err_pulse", 64'(n_err), 64'd1);
    chk("bad_no_beats", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
    send(2'd1, 1, 8'h07, 64'hF000_0000_0000_0060, 0);
    check_pkt("after_bad", 31'd103, 29'd3, 32'h55, 32'hC0A80010, 16'd9000, 1, 8'h07, 64'hF000_0000_0000_0060, ts);
    cfg(2'd2, 32'hC0A80020, 16'd7000, 32'hAB, 31'h7FFFFFFF);
    send(2'd2, 1, 8'hFF, 64'h1000_0000_0000_0070, 0);
    check_pkt("pre_wrap", 31'h7FFFFFFF, 29'd0, 32'hAB, 32'hC0A80020, 16'd7000, 1, 8'hFF, 64'h1000_0000_0000_0070, ts);
    send(2'd2, 2, 8'hFF, 64'h2000_0000_0000_0080, 1);
    check_pkt("wrap", 31'd0, 29'd1, 32'hAB, 32'hC0A80020, 16'd7000, 2, 8'hFF, 64'h2000_0000_0000_0080, ts);
    send(2'd2, 1, 8'h03, 64'h3000_0000_0000_0090, 0);
    check_pkt("collide", 31'd5, 29'd0, 32'hAB, 32'hC0A80020, 16'd7000, 1, 8'h03, 64'h3000_0000_0000_0090, ts);
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    repeat (40) @(posedge clk);
    #1;
    send(2'd1, 1, 8'hFF, 64'h4000_0000_0000_00A0, 0);
    check_pkt("tstamp", 31'd0, 29'd0, 32'd0, 32'd0, 16'd0, 1, 8'hFF, 64'h4000_0000_0000_00A0, ts);
`ifdef UDT_TX_TSTAMP_EN
    chk("tstamp_range", 64'(ts >= 32'd9 && ts <= 32'd11), 64'd1);
`else
    chk("tstamp_zero", 64'(ts), 64'd0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/udt_data_tx_framer.md
# udt_data_tx_framer

Multi-socket UDT data-packet framer in the UDP clock domain, between the UDT transmit buffer and the UDP/IP transmit engine. Takes payload packets on a 64-bit AXI-Stream tagged with a socket index, prepends the 16-byte UDT data header and drives the `udp_tx_*` interface. The header carries a per-socket sequence number, a message number and a timestamp. Destination IP, port and peer socket ID come from a runtime-writable socket table.

## Interface
- `NUM_SOCK`, 4: number of sockets.
- `SOCK_W`, 2: socket index width; must be ≥ 1 and satisfy 2^SOCK_W ≥ NUM_SOCK.
- `FPGA_MAC_SRC`, 48'hba0203040506: source MAC.
- `FPGA_MAC_DES`, 48'hffffffffffff: destination MAC.
- `FPGA_IP_SRC`, 32'hc0a8006f: source IP.
- `PORT`, 10086: UDP source port.
- `CLK_PER_US`, 156: `udp_clk` cycles per microsecond.
- `udp_clk` in 1: only clock.
- `udp_areset` in 1: reset; synchronous to `udp_clk`, active-high.
- `s_axis_tvalid` in 1, `s_axis_tready` out 1, `s_axis_tdata` in 64, `s_axis_tkeep` in 8, `s_axis_tlast` in 1: payload stream.
- `s_axis_tdest` in SOCK_W: socket index; sampled on the first beat of each packet.
- `cfg_we` in 1: socket table write strobe.
- `cfg_sock` in SOCK_W: table entry to write.
- `cfg_ip_dest` in 32, `cfg_port_dest` in 16, `cfg_peer_id` in 32: destination fields for the entry.
- `cfg_seq_init` in 31: initial sequence number for the entry; the write also clears that entry's message number.
- `udp_tx_tready` in 1, `udp_tx_tvalid` out 1, `udp_tx_tlast` out 1, `udp_tx_tkeep` out 8, `udp_tx_tdata` out 64: UDP transmit stream.
- `udp_tx_mac_src` out 48, `udp_tx_mac_dest` out 48, `udp_tx_ip_src` out 32, `udp_tx_ip_dest` out 32, `udp_tx_port_src` out 16, `udp_tx_port_dest` out 16: per-packet sideband.
- `err_bad_sock` out 1: one-cycle pulse when a packet is dropped.

## Operation
- **Socket table:** per entry `{ip_dest, port_dest, peer_id, seq[30:0], msgno[28:0]}`.
  - Reset clears every field to 0.
- **Byte order:** network order, byte 0 on the wire in `tdata[7:0]`.
- **Header beat 0:** word0 = `{1'b0, seq}`, then word1 = `{2'b11, 1'b0, msgno}`.
- **Header beat 1:** word2 = timestamp, then word3 = `peer_id`.
- **FSM states:** IDLE, HDR0, HDR1, DATA, DROP.
- **IDLE:**
  - `s_axis_tready` = 0.
  - On `s_axis_tvalid`, if `tdest < NUM_SOCK`: latch the table entry and the timestamp into packet registers, go to HDR0.
  - Otherwise go to DROP.
- **HDR0 / HDR1:**
  - `udp_tx_tvalid` = 1, `tkeep` = 8'hFF, `tlast` = 0.
  - Advance only on `udp_tx_tready`.
- **DATA:** combinational pass-through.
  - `udp_tx_tvalid` = `s_axis_tvalid`; `s_axis_tready` = `udp_tx_tready`.
  - `tdata`, `tkeep` and `tlast` are passed through unchanged.
  - On the `tlast` handshake: the entry's `seq` += 1 (wraps 0x7FFFFFFF→0) and `msgno` += 1 (wraps 29'h1FFFFFFF→0); go to IDLE.
- **DROP:**
  - `s_axis_tready` = 1; beats are discarded and `udp_tx_tvalid` = 0.
  - On the `tlast` handshake: pulse `err_bad_sock`, go to IDLE. The table is unchanged.
- **Sideband outputs:** driven from the packet registers and held stable from entry to HDR0 until the `tlast` handshake. The MAC, source-IP and source-port outputs are the constant parameters.
- **Config writes:**
  - Applied in the cycle of `cfg_we`.
  - A write to the socket currently in flight does not affect that packet.
  - If a write coincides with the end-of-packet increment on the same socket, the write wins.
- **Input rule:** `s_axis_tkeep` is contiguous from bit 0 and is all-ones except on the `tlast` beat. The block does not check this.

## Timing
- **Reset values:**
  - State = IDLE.
  - `udp_tx_tvalid`, `udp_tx_tlast`, `s_axis_tready`, `err_bad_sock` = 0.
  - `udp_tx_tdata`, `udp_tx_tkeep`, `udp_tx_ip_dest`, `udp_tx_port_dest` = 0.
  - Timestamp counters = 0.
- **Latency:** first input valid → header beat 0 valid is 1 cycle; header costs 2 beats.
- **Back-to-back:** next packet starts 1 cycle after `tlast` (one IDLE cycle).
- **Reset mid-packet:** the FSM returns to IDLE immediately; the partial packet is abandoned; the table is cleared.
- **Throughput:** `udp_tx_tvalid` never deasserts while in HDR0/HDR1 without a handshake.

## Configuration
- **`UDT_TX_TSTAMP_EN` defined:**
  - A cycle prescaler counts 0..CLK_PER_US−1.
  - A free-running 32-bit microsecond counter increments on each prescaler wrap and itself wraps to 0.
  - word2 is this counter, sampled at IDLE→HDR0.
- **Not defined:** word2 = 32'h0 and no counters are built.

## Test plan
- **Basic framing:**
  - Stimulus: write sock 1 `{ip 0xC0A80010, port 9000, peer 0x55, seq 100}`, then send a 3-beat packet on tdest 1 with last `tkeep` = 8'h0F.
  - Required: 5 output beats; beat0 bytes = `00 00 00 64 C0 00 00 00`; beat 4 `tkeep` = 8'h0F with `tlast`; sideband ip/port match throughout.
- **Sequence advance:** second packet on sock 1 → seq 101 and msgno 1.
  - A packet on sock 0 in between shows seq 0 and does not disturb sock 1.
- **Back-pressure:**
  - Stimulus: randomly toggle `udp_tx_tready` during the header and payload.
  - Required: no beat lost or duplicated; `tvalid` held while stalled in a header state.
- **Bad socket:**
  - Stimulus: with `NUM_SOCK` = 3, send a 2-beat packet on tdest 3.
  - Required: no `udp_tx_tvalid`, one `err_bad_sock` pulse, next valid packet framed normally.
- **Wrap and collision:**
  - Stimulus: seq init 0x7FFFFFFF, send one packet; then `cfg_we` with seq init 5 in the same cycle as the `tlast` handshake on that socket.
  - Required: the first packet after the wrap shows seq 0; after the collision the next packet shows seq 5 and msgno 0.
- **Timestamp (`UDT_TX_TSTAMP_EN`):**
  - Stimulus: with `CLK_PER_US` = 4, start a packet after 40 cycles.
  - Required: word2 = 10 ± 1.
  - Without the macro, word2 = 0.
